decoder3x8_pulser: RTL

//  Receive side of the 8x3 encoder path. Accepts a 3-bit code with a valid/ready handshake.

---
 rtl/decoder3x8_pulser.sv | 124 ++++++++++++
 1 files changed

// File: rtl/decoder3x8_pulser.sv
// Receive-side 3-to-8 decoder: accepts a code over valid/ready, drives the one-hot
// select for HOLD cycles, then stays idle for GAP cycles before accepting the next code.
module decoder3x8_pulser #(
    parameter int HOLD = 4,
    parameter int GAP  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in,
    output logic [7:0] out,
    output logic       out_valid,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD - 1);
    localparam logic [7:0] GAP_LOAD  = 8'(GAP - 1);

    function automatic logic [7:0] decode_onehot(input logic [2:0] code);
        decode_onehot = 8'd1 << code;
    endfunction

    state_t     state_r;
    state_t     state_s;
    logic [7:0] cnt_r;
    logic [7:0] cnt_s;
    logic [7:0] out_r;
    logic [7:0] out_s;
    logic       out_valid_r;
    logic       done_r;
    logic       done_s;
    logic       accept_s;

    // Ready depends only on state, enable and reset, never on in_valid.
    assign in_ready  = en & ~rst & (state_r == ST_IDLE);
    assign accept_s  = in_valid & in_ready;
    assign out       = out_r;
    assign out_valid = out_valid_r;
    assign done      = done_r;

    // Next-state, counter and next-output computation.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        out_s   = out_r;
        if (!en) begin
            state_s = ST_IDLE;
            cnt_s   = 8'd0;
            out_s   = 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_s = ST_DRIVE;
                        cnt_s   = HOLD_LOAD;
                        out_s   = decode_onehot(in);
                    end else begin
                        state_s = ST_IDLE;
                        cnt_s   = cnt_r;
                        out_s   = 8'd0;
                    end
                end
                ST_DRIVE: begin
                    if (cnt_r != 8'd0) begin
                        cnt_s = cnt_r - 8'd1;
                        out_s = out_r;
                    end else begin
                        out_s = 8'd0;
                        if (GAP > 0) begin
                            state_s = ST_GAP;
                            cnt_s   = GAP_LOAD;
                        end else begin
                            state_s = ST_IDLE;
                            cnt_s   = 8'd0;
                        end
                    end
                end
                ST_GAP: begin
                    if (cnt_r != 8'd0) begin
                        cnt_s = cnt_r - 8'd1;
                    end else begin
                        state_s = ST_IDLE;
                        cnt_s   = 8'd0;
                    end
                    out_s = 8'd0;
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = 8'd0;
                    out_s   = 8'd0;
                end
            endcase
        end
    end

    // done is registered one cycle early: it marks the cycle that holds the final DRIVE count.
    assign done_s = (state_s == ST_DRIVE) && (cnt_s == 8'd0);

    // State, counter and registered outputs; reset wins over enable and handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 8'd0;
            out_r       <= 8'd0;
            out_valid_r <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            out_r       <= out_s;
            out_valid_r <= |out_s;
            done_r      <= done_s;
        end
    end

endmodule
